// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide engine producing the HI/LO pair for MULT, MULTU,
// DIV and DIVU. One operand bit is processed per clock. Signed operations
// run on magnitudes, and the sign is applied in a final fix-up cycle.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears all state
//   start    : launch request, sampled only while idle
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     : multiplicand/dividend, multiplier/divisor
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse when hi/lo carry a new result
//   div_zero : divide with zero divisor; held until the next accepted start
//   hi, lo   : product upper/lower half, or remainder/quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic                   isDiv;
  logic                   negLo;    // negate product (multiply) or quotient (divide)
  logic                   negRem;   // negate remainder (divide only)
  logic [2*WIDTH-1:0]     acc;      // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
  logic [WIDTH-1:0]       opnd;     // multiplicand or divisor magnitude

  // Two's-complement magnitude when the operand is treated as signed.
  // |MIN| comes out as 2^(WIDTH-1), which is representable unsigned.
  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v,
                                               input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] negHalf(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negWide(input logic [2*WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  // Request decode and operand conditioning
  logic             reqSigned;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  always_comb begin
    reqSigned = ~op[0];
    signA     = reqSigned & a[WIDTH-1];
    signB     = reqSigned & b[WIDTH-1];
    magA      = absVal(a, reqSigned);
    magB      = absVal(b, reqSigned);
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       divTrial;
  logic [WIDTH+1:0]     divDiff;
  logic [2*WIDTH-1:0]   accNext;

  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff  = {1'b0, divTrial} - {2'b00, opnd};
    accNext  = acc;
    if (isDiv) begin
      // A non-negative trial difference means the divisor fits: keep it, quotient bit 1.
      if (!divDiff[WIDTH+1]) begin
        accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        accNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      accNext = {mulSum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied in the final cycle
  logic [2*WIDTH-1:0] fixProd;
  logic [WIDTH-1:0]   fixQuo;
  logic [WIDTH-1:0]   fixRem;

  always_comb begin
    fixProd = negWide(acc, negLo);
    fixQuo  = negHalf(acc[WIDTH-1:0], negLo);
    fixRem  = negHalf(acc[2*WIDTH-1:WIDTH], negRem);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      isDiv    <= 1'b0;
      negLo    <= 1'b0;
      negRem   <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            isDiv    <= op[1];
            busy     <= 1'b1;
            div_zero <= 1'b0;
            if (op[1] && (b == '0)) begin
              // Preload the fix-up path so it yields hi=a, lo=all ones unchanged.
              div_zero <= 1'b1;
              acc      <= {a, {WIDTH{1'b1}}};
              opnd     <= '0;
              negLo    <= 1'b0;
              negRem   <= 1'b0;
              count    <= '0;
              state    <= FIX;
            end else begin
              count <= CNT_LOAD;
              negLo <= signA ^ signB;
              state <= RUN;
              if (op[1]) begin
                acc    <= {{WIDTH{1'b0}}, magA};
                opnd   <= magB;
                negRem <= signA;
              end else begin
                acc    <= {{WIDTH{1'b0}}, magB};
                opnd   <= magA;
                negRem <= 1'b0;
              end
            end
          end
        end

        RUN: begin
          acc   <= accNext;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (isDiv) begin
            hi <= fixRem;
            lo <= fixQuo;
          end else begin
            hi <= fixProd[2*WIDTH-1:WIDTH];
            lo <= fixProd[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock;
  logic        reset;

  logic        start32;
  logic [1:0]  op32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic        dz32;
  logic [31:0] hi32;
  logic [31:0] lo32;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic        dz8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation on the 32-bit unit and wait (bounded) for done.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busyCnt, output logic dz0);
    op32    = o;
    a32     = x;
    b32     = y;
    start32 = 1'b1;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    dz0     = dz32;
    lat     = 0;
    busyCnt = busy32 ? 1 : 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (busy32) busyCnt++;
      if (done32) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   busyCnt;
    logic dz0;

    reset   = 1'b0;
    start32 = 1'b0;
    op32    = 2'b00;
    a32     = '0;
    b32     = '0;
    start8  = 1'b0;
    op8     = 2'b00;
    a8      = '0;
    b8      = '0;

    #12;
    check("reset_busy", busy32, 0);
    check("reset_done", done32, 0);
    check("reset_divzero", dz32, 0);
    check("reset_hilo", {hi32, lo32}, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // MULT -3 * 5
    run32(2'b00, 32'hFFFF_FFFD, 32'd5, lat, busyCnt, dz0);
    check("mult_latency", lat, 33);
    check("mult_busy_cycles", busyCnt, 33);
    check("mult_hi", hi32, 32'hFFFF_FFFF);
    check("mult_lo", lo32, 32'hFFFF_FFF1);
    @(posedge clock);
    #1;
    check("done_one_cycle", done32, 0);

    // MULTU FFFFFFFF * FFFFFFFF
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, dz0);
    check("multu_hi", hi32, 32'hFFFF_FFFE);
    check("multu_lo", lo32, 32'h0000_0001);

    // DIVU 100 / 7, launched in the done cycle of the previous op
    run32(2'b11, 32'd100, 32'd7, lat, busyCnt, dz0);
    check("divu_latency", lat, 33);
    check("divu_lo", lo32, 32'd14);
    check("divu_hi", hi32, 32'd2);

    // DIV -7 / 2
    run32(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busyCnt, dz0);
    check("div_neg_a_lo", lo32, 32'hFFFF_FFFD);
    check("div_neg_a_hi", hi32, 32'hFFFF_FFFF);

    // DIV 7 / -2
    run32(2'b10, 32'd7, 32'hFFFF_FFFE, lat, busyCnt, dz0);
    check("div_neg_b_lo", lo32, 32'hFFFF_FFFD);
    check("div_neg_b_hi", hi32, 32'd1);

    // DIVU 0x1234 / 0
    run32(2'b11, 32'h0000_1234, 32'd0, lat, busyCnt, dz0);
    check("divzero_flag_edge0", dz0, 1);
    check("divzero_latency", lat, 1);
    check("divzero_hi", hi32, 32'h0000_1234);
    check("divzero_lo", lo32, 32'hFFFF_FFFF);
    check("divzero_held", dz32, 1);

    // MULT 2 * 3 clears div_zero at its sampling edge
    run32(2'b00, 32'd2, 32'd3, lat, busyCnt, dz0);
    check("divzero_cleared", dz0, 0);
    check("small_mult_hilo", {hi32, lo32}, 64'd6);

    // WIDTH=8: DIV MIN / -1
    op8    = 2'b10;
    a8     = 8'h80;
    b8     = 8'hFF;
    start8 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    lat    = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
    check("w8_latency", lat, 9);
    check("w8_lo", lo8, 8'h80);
    check("w8_hi", hi8, 8'h00);
    check("w8_divzero", dz8, 0);

    // start pulsed mid-RUN with different operands is ignored
    op32    = 2'b00;
    a32     = 32'hFFFF_FFFD;
    b32     = 32'd5;
    start32 = 1'b1;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    lat     = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n == 5) begin
        op32    = 2'b01;
        a32     = 32'hFFFF_FFFF;
        b32     = 32'hFFFF_FFFF;
        start32 = 1'b1;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done32) begin
        lat = n;
        break;
      end
    end
    start32 = 1'b0;
    check("ignore_start_latency", lat, 33);
    check("ignore_start_hi", hi32, 32'hFFFF_FFFF);
    check("ignore_start_lo", lo32, 32'hFFFF_FFF1);

    // Asynchronous reset mid-RUN
    op32    = 2'b11;
    a32     = 32'd100;
    b32     = 32'd7;
    start32 = 1'b1;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    check("midrun_busy_before", busy32, 1);
    reset = 1'b0;
    #1;
    check("midrun_reset_busy", busy32, 0);
    check("midrun_reset_done", done32, 0);
    check("midrun_reset_divzero", dz32, 0);
    check("midrun_reset_hilo", {hi32, lo32}, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    run32(2'b11, 32'd100, 32'd7, lat, busyCnt, dz0);
    check("after_reset_latency", lat, 33);
    check("after_reset_lo", lo32, 32'd14);
    check("after_reset_hi", hi32, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide engine that produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. The control unit launches it with a start pulse and waits on done, with the result registered internally. It generalises the fixed 32-bit mult/div path in datapath width and in signed/unsigned mode, and adds a busy/done handshake and divide-by-zero detection. It sits between the A/B operand registers and the HI/LO registers of the multi-cycle CPU.

## Interface
- WIDTH, 32: operand and result-half width; must be ≥ 4.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low. Clears all state.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi and lo are valid.
- div_zero  out  1  set when a DIV or DIVU has a zero divisor; held until the next accepted start.
- hi  out  WIDTH  multiply: upper product half. Divide: remainder.
- lo  out  WIDTH  multiply: lower product half. Divide: quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1: the unit captures op and the operand magnitudes. For signed ops it takes |a| and |b| as unsigned WIDTH-bit values; |MIN| = 2^(WIDTH-1). It records the result sign flags, loads the iteration counter with WIDTH, and goes to RUN.
- IDLE with start=1 on a divide and b==0: the unit sets div_zero and goes directly to FIX without computing. The FIX result is hi=a, lo={WIDTH{1}}.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN: the counter decrements every cycle. On the last iteration (counter reaches 1) the next state is FIX.
- FIX, multiply: if signed and the operand signs differ, the unit negates the 2·WIDTH product. It then writes hi and lo.
- FIX, divide: if signed, quotient sign is sign(a) XOR sign(b) and the quotient truncates toward zero. Remainder sign follows a. The unit writes lo=quotient, hi=remainder.
- MIN / -1 (signed) gives lo=MIN (wraps) and hi=0. No overflow flag is raised.
- FIX: done=1 for exactly one cycle, then the state returns to IDLE.
- start while busy: ignored. Operands and op are not re-sampled.
- hi and lo hold their last result until the next FIX. They change only at the FIX edge.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. The in-flight operation is discarded.

## Timing
- Edge 0 samples start. busy=1 after edge 0.
- Normal operation: edges 1..WIDTH are RUN iterations. Edge WIDTH+1 (FIX) updates hi/lo, asserts done and deasserts busy in the same cycle.
- Normal-operation latency: WIDTH+1 edges from the start-sampling edge to done high. For WIDTH=32 that is 33 edges.
- Divide-by-zero: edge 1 is FIX. done is high after edge 1 (latency 1 edge). div_zero rises after edge 0.
- Back-to-back: during the cycle done=1 the state is IDLE, so a start in that cycle is accepted. The minimum start-to-start spacing is WIDTH+2 cycles.
- Outputs are registered. There is no combinational path from the inputs to busy, done, hi or lo.

## Test plan
- MULT, WIDTH=32, a=-3 (FFFFFFFD), b=5: hi=FFFFFFFF, lo=FFFFFFF1. done 33 edges after start; busy high for exactly those 33 cycles.
- MULTU, a=b=FFFFFFFF: hi=FFFFFFFE, lo=00000001. DIVU a=100, b=7: lo=14, hi=2.
- DIV, a=-7, b=2: lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIV, a=7, b=-2: lo=-3, hi=1.
- DIVU, a=0x1234, b=0: div_zero=1 and done after 1 edge; hi=0x1234, lo=FFFFFFFF. A following MULT start clears div_zero at its sampling edge.
- WIDTH=8 instance, DIV a=0x80, b=0xFF: lo=0x80, hi=0x00, done after 9 edges.
- start pulsed again mid-RUN with different operands: ignored, first result unchanged. Then reset low mid-RUN: busy, done and div_zero drop to 0 and hi=lo=0 immediately (asynchronous). After reset release, a new start completes normally.
